// File: rtl/gfx_shift_loader.sv
// gfx_shift_loader
//
// Upstream sequencer for four ttl_74194_sync pixel shift registers, one per
// bitplane. ROM words arrive over a valid/ready handshake into a 2-entry FIFO.
// On every pixel tick (rising edge of Cen as seen on CP) the registered mode
// pins and parallel data are updated. Phase 0 of each 4-tick group is a
// parallel load and phases 1..3 are shifts.
//
// Optional feature: define GFX_LOADER_FLIP_EN to honour `flip`. It is sampled
// at each load and selects shift-left for the rest of that group.
//
// Ports:
//   CP          system clock, rising edge
//   Reset       asynchronous active-high reset
//   Cen         pixel enable; a tick is Cen=1 with previous sampled Cen=0
//   line_start  one-cycle line restart (flush, phase 0, clear shifters)
//   word_in     16-bit ROM word, plane p in bits [4p+3:4p]
//   word_valid  word_in is valid
//   word_ready  FIFO can accept a word
//   flip        horizontal flip request (GFX_LOADER_FLIP_EN builds only)
//   S0, S1      mode for all four shifters
//   D           parallel data, plane p D0..D3 = D[4p+0..4p+3]
//   Dsr, Dsl    serial fill, tied 0
//   underflow   sticky: a load found the FIFO empty; cleared by line_start
module gfx_shift_loader (
  input  logic        CP,
  input  logic        Reset,
  input  logic        Cen,
  input  logic        line_start,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic        flip,
  output logic        S0,
  output logic        S1,
  output logic [15:0] D,
  output logic        Dsr,
  output logic        Dsl,
  output logic        underflow
);

  logic        last_cen;
  logic [1:0]  phase;
  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [15:0] mem [0:1];
  logic [1:0]  mode;
  logic [1:0]  shift_mode;

  logic tick;
  logic push;
  logic load_tick;
  logic pop;

  assign tick = Cen & ~last_cen;

  // Handshake: a word transfers on a CP edge where word_valid and word_ready
  // are both 1. word_ready depends only on count, Reset and line_start, never
  // on word_valid, so the producer may hold word_valid until it sees ready.
  assign word_ready = (count != 2'd2) & ~Reset & ~line_start;
  assign push       = word_valid & word_ready;

  // line_start overrides a tick in the same cycle, so no pop happens then.
  assign load_tick = tick & (phase == 2'd0) & ~line_start;
  assign pop       = load_tick & (count != 2'd0);

`ifdef GFX_LOADER_FLIP_EN
  logic flip_grp;

  // flip is latched once per group so mid-group changes take effect at the
  // next load only.
  always_ff @(posedge CP or posedge Reset) begin
    if (Reset) begin
      flip_grp <= 1'b0;
    end else if (load_tick) begin
      flip_grp <= flip;
    end
  end

  assign shift_mode = flip_grp ? 2'b10 : 2'b01;
`else
  logic unused_flip;
  assign unused_flip = flip;
  assign shift_mode  = 2'b01;
`endif

  // FIFO storage needs no reset: count alone decides what is valid.
  always_ff @(posedge CP) begin
    if (push) begin
      mem[wr_ptr] <= word_in;
    end
  end

  always_ff @(posedge CP or posedge Reset) begin
    if (Reset) begin
      last_cen  <= 1'b1;   // suppress a spurious tick right after release
      phase     <= 2'd0;
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      mode      <= 2'b00;
      D         <= 16'h0000;
      underflow <= 1'b0;
    end else begin
      last_cen <= Cen;
      if (line_start) begin
        count     <= 2'd0;
        wr_ptr    <= 1'b0;
        rd_ptr    <= 1'b0;
        phase     <= 2'd0;
        mode      <= 2'b11;  // load zeros on the next tick: shifters cleared
        D         <= 16'h0000;
        underflow <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
        if (tick) begin
          phase <= phase + 2'd1;
          if (phase == 2'd0) begin
            mode <= 2'b11;
            // A word pushed on this same edge is not visible yet: no
            // fall-through, the load sees an empty FIFO.
            if (pop) begin
              D <= mem[rd_ptr];
            end else begin
              D         <= 16'h0000;
              underflow <= 1'b1;
            end
          end else begin
            mode <= shift_mode;
          end
        end
      end
    end
  end

  assign S1  = mode[1];
  assign S0  = mode[0];
  assign Dsr = 1'b0;
  assign Dsl = 1'b0;

endmodule

// File: tb/tb_gfx_shift_loader.sv
module tb_gfx_shift_loader;

  logic        CP = 1'b0;
  logic        Reset;
  logic        Cen;
  logic        line_start;
  logic [15:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        flip;
  logic        S0;
  logic        S1;
  logic [15:0] D;
  logic        Dsr;
  logic        Dsl;
  logic        underflow;

`ifdef GFX_LOADER_FLIP_EN
  localparam bit FLIP_EN = 1'b1;
`else
  localparam bit FLIP_EN = 1'b0;
`endif

  gfx_shift_loader dut (
    .CP         (CP),
    .Reset      (Reset),
    .Cen        (Cen),
    .line_start (line_start),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .flip       (flip),
    .S0         (S0),
    .S1         (S1),
    .D          (D),
    .Dsr        (Dsr),
    .Dsl        (Dsl),
    .underflow  (underflow)
  );

  // ---------------- clock ----------------
  always #5 CP = ~CP;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Behavioural view: a word queue, a tick counter modulo 4, and the
  // operation announced to the shifters for the next tick.
  logic [15:0] m_q[$];
  int          m_phase;
  logic        m_last_cen;
  logic [1:0]  m_s;
  logic [15:0] m_d;
  logic        m_uf;
  logic        m_flip_grp;

  task automatic model_reset();
    m_q.delete();
    m_phase    = 0;
    m_last_cen = 1'b1;
    m_s        = 2'b00;
    m_d        = 16'h0000;
    m_uf       = 1'b0;
    m_flip_grp = 1'b0;
  endtask

  function automatic logic m_ready();
    return (m_q.size() < 2) && !line_start;
  endfunction

  // Called at each CP rising edge with the inputs that edge samples.
  task automatic model_step();
    logic rdy;
    logic tk;
    rdy = m_ready();
    tk  = Cen && !m_last_cen;
    m_last_cen = Cen;
    if (line_start) begin
      m_q.delete();
      m_phase = 0;
      m_s     = 2'b11;
      m_d     = 16'h0000;
      m_uf    = 1'b0;
    end else begin
      if (tk) begin
        if (m_phase == 0) begin
          m_s        = 2'b11;
          m_flip_grp = flip;
          if (m_q.size() > 0) m_d = m_q.pop_front();
          else begin
            m_d  = 16'h0000;
            m_uf = 1'b1;
          end
        end else begin
          m_s = (FLIP_EN && m_flip_grp) ? 2'b10 : 2'b01;
        end
        m_phase = (m_phase + 1) % 4;
      end
      if (word_valid && rdy) m_q.push_back(word_in);
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("mode", {30'd0, S1, S0}, {30'd0, m_s});
    chk("data", {16'd0, D}, {16'd0, m_d});
    chk("underflow", {31'd0, underflow}, {31'd0, m_uf});
    chk("serial_fill", {30'd0, Dsr, Dsl}, 32'd0);
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic c, input logic ls, input logic v,
                       input logic [15:0] w, input logic f);
    Cen        = c;
    line_start = ls;
    word_valid = v;
    word_in    = w;
    flip       = f;
    #1;
  endtask

  task automatic finish_step();
    chk("word_ready", {31'd0, word_ready}, {31'd0, m_ready()});
    @(posedge CP);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic step_chk(input logic c, input logic ls, input logic v,
                          input logic [15:0] w, input logic f);
    drive(c, ls, v, w, f);
    finish_step();
  endtask

  // n full Cen pulses with no pushes
  task automatic tick_n(input int n, input logic f);
    for (int k = 0; k < n; k++) begin
      step_chk(1'b1, 1'b0, 1'b0, 16'h0000, f);
      step_chk(1'b0, 1'b0, 1'b0, 16'h0000, f);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        cen;
    logic        ls;
    logic        valid;
    logic [15:0] word;
    logic [1:0]  s;
    logic [15:0] d;
    logic        rdy;
    logic        uf;
  } vec_t;

  vec_t tbl[22];

  initial begin
    // ---- vectors: line_start, two pushes, 9 ticks, underflow, line_start
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 2'd3, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 16'h1234, 2'd3, 16'h0000, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'hABCD, 2'd3, 16'h0000, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd3, 16'h1234, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd3, 16'h1234, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 16'h1234, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd1, 16'h1234, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 16'h1234, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd1, 16'h1234, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 16'h1234, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd1, 16'h1234, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd3, 16'hABCD, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd3, 16'hABCD, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 16'hABCD, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd1, 16'hABCD, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 16'hABCD, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd1, 16'hABCD, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd1, 16'hABCD, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd1, 16'hABCD, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd3, 16'h0000, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd3, 16'h0000, 1'b1, 1'b1};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 16'h0000, 2'd3, 16'h0000, 1'b0, 1'b0};

    // ---- reset with Cen held high
    Reset = 1'b1; Cen = 1'b1; line_start = 1'b0;
    word_valid = 1'b0; word_in = 16'h0000; flip = 1'b0;
    model_reset();
    @(posedge CP); @(posedge CP); #1;
    chk("rst_mode", {30'd0, S1, S0}, 32'd0);
    chk("rst_data", {16'd0, D}, 32'd0);
    chk("rst_underflow", {31'd0, underflow}, 32'd0);
    chk("rst_ready", {31'd0, word_ready}, 32'd0);
    Reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step_chk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("post_rst_mode", {30'd0, S1, S0}, 32'd0);
    chk("post_rst_ready", {31'd0, word_ready}, 32'd1);

    // ---- table-driven sequence
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].cen, tbl[i].ls, tbl[i].valid, tbl[i].word, 1'b0);
      chk($sformatf("tbl%0d_ready", i), {31'd0, word_ready}, {31'd0, tbl[i].rdy});
      @(posedge CP);
      model_step();
      #1;
      chk($sformatf("tbl%0d_mode", i), {30'd0, S1, S0}, {30'd0, tbl[i].s});
      chk($sformatf("tbl%0d_data", i), {16'd0, D}, {16'd0, tbl[i].d});
      chk($sformatf("tbl%0d_uf", i), {31'd0, underflow}, {31'd0, tbl[i].uf});
    end

    // ---- three back-to-back pushes: third stalls until a load pops
    step_chk(1'b0, 1'b0, 1'b1, 16'hA1A1, 1'b0);
    step_chk(1'b0, 1'b0, 1'b1, 16'hB2B2, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 16'hC3C3, 1'b0);
    chk("stall_ready_full", {31'd0, word_ready}, 32'd0);
    finish_step();
    drive(1'b1, 1'b0, 1'b1, 16'hC3C3, 1'b0);
    chk("stall_ready_at_load", {31'd0, word_ready}, 32'd0);
    finish_step();
    chk("stall_load_a", {16'd0, D}, 32'h0000A1A1);
    drive(1'b0, 1'b0, 1'b1, 16'hC3C3, 1'b0);
    chk("stall_ready_after_pop", {31'd0, word_ready}, 32'd1);
    finish_step();
    tick_n(3, 1'b0);
    tick_n(1, 1'b0);
    chk("stall_load_b", {16'd0, D}, 32'h0000B2B2);
    tick_n(4, 1'b0);
    chk("stall_load_c", {16'd0, D}, 32'h0000C3C3);
    chk("stall_no_uf", {31'd0, underflow}, 32'd0);

    // ---- line_start with full FIFO and a word offered
    tick_n(3, 1'b0);
    step_chk(1'b0, 1'b0, 1'b1, 16'h1111, 1'b0);
    step_chk(1'b0, 1'b0, 1'b1, 16'h2222, 1'b0);
    step_chk(1'b0, 1'b1, 1'b1, 16'h7777, 1'b0);
    chk("ls_mode", {30'd0, S1, S0}, 32'd3);
    chk("ls_data", {16'd0, D}, 32'd0);
    tick_n(1, 1'b0);
    chk("ls_flushed_data", {16'd0, D}, 32'd0);
    chk("ls_flushed_uf", {31'd0, underflow}, 32'd1);

    // ---- push into empty FIFO on the load edge: no fall-through
    step_chk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    step_chk(1'b1, 1'b0, 1'b1, 16'h5555, 1'b0);
    chk("nofall_data", {16'd0, D}, 32'd0);
    chk("nofall_uf", {31'd0, underflow}, 32'd1);
    step_chk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick_n(3, 1'b0);
    tick_n(1, 1'b0);
    chk("nofall_kept", {16'd0, D}, 32'h00005555);

`ifdef GFX_LOADER_FLIP_EN
    // ---- flip sampled at the load, ignored mid-group
    step_chk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    step_chk(1'b0, 1'b0, 1'b1, 16'h9999, 1'b1);
    step_chk(1'b0, 1'b0, 1'b1, 16'h8888, 1'b1);
    tick_n(1, 1'b1);
    chk("flip_load", {16'd0, D}, 32'h00009999);
    for (int k = 0; k < 3; k++) begin
      tick_n(1, 1'b0);
      chk("flip_left", {30'd0, S1, S0}, 32'd2);
    end
    tick_n(1, 1'b0);
    chk("flip_load2", {30'd0, S1, S0}, 32'd3);
    tick_n(1, 1'b1);
    chk("flip_off_right", {30'd0, S1, S0}, 32'd1);
`endif

    // ---- randomized run against the model, with one async reset mid-way
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        Reset = 1'b1;
        #2;
        chk("async_rst_mode", {30'd0, S1, S0}, 32'd0);
        chk("async_rst_data", {16'd0, D}, 32'd0);
        chk("async_rst_uf", {31'd0, underflow}, 32'd0);
        chk("async_rst_ready", {31'd0, word_ready}, 32'd0);
        @(posedge CP); #1;
        Reset = 1'b0;
        model_reset();
      end
      step_chk(1'($urandom_range(0, 1)),
               1'($urandom_range(0, 39) == 0),
               1'($urandom_range(0, 9) < 6),
               16'($urandom),
               1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gfx_shift_loader.md
# gfx_shift_loader

Upstream sequencer for a bank of four `ttl_74194_sync` pixel shift registers, one per bitplane.
- Accepts 16-bit graphics ROM words over a valid/ready handshake and buffers them in a 2-entry FIFO.
- On every pixel tick it drives the mode pins (`S1`,`S0`) and parallel data (`D`) of all four shifters: a parallel load every fourth tick, a shift on the other three.
- Sits between the tile/sprite ROM fetch logic and the 74194 serializers in the video path.

## Interface
Parameters:
- none

Ports:
- `CP` input 1: system clock; all state updates on rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `Cen` input 1: pixel enable. A pixel tick is a `CP` edge where `Cen`=1 and the previous sampled `Cen`=0; this is the same edge-detect convention the shifters use.
- `line_start` input 1: synchronous, one `CP` wide; starts a new line.
- `word_in` input 16: ROM word. Plane p occupies bits [4p+3:4p].
- `word_valid` input 1: `word_in` is valid.
- `word_ready` output 1: FIFO can accept a word.
- `flip` input 1: horizontal flip request. Used only when `GFX_LOADER_FLIP_EN` is defined.
- `S0`, `S1` output 1 each: mode for all four shifters.
- `D` output 16: parallel data. Plane p's `D0..D3` = `D[4p+0..4p+3]`.
- `Dsr`, `Dsl` output 1 each: serial fill for the shifters, tied 0.
- `underflow` output 1: sticky flag, set when a load found the FIFO empty.

## Operation
State:
- `last_cen`
- 2-bit `phase`
- 2-entry FIFO: `count` 0..2, read/write pointers
- registered `S1`,`S0`,`D`
- `underflow`

Push:
- `word_ready` = (`count`<2), forced 0 while `Reset` is high and in any cycle where `line_start`=1.
- A push occurs on a `CP` edge with `word_valid`=1 and `word_ready`=1.

Pixel tick:
- Outputs are registered and describe the shifter operation for the next pixel tick.
- phase==0:
  - FIFO non-empty: pop and drive `S1S0`=11, `D`=popped word.
  - FIFO empty: drive `S1S0`=11, `D`=0, and set `underflow`.
- phase 1..3: drive `S1S0`=01 (shift right), `D` holds its last value.
- `phase` increments modulo 4 on each tick.

Between ticks:
- `S1S0`, `D` and `phase` hold.

`line_start`:
- Flushes the FIFO (`count`=0).
- Sets `phase`=0, `S1S0`=11, `D`=0, so the shifters are cleared on the next tick.
- Clears `underflow`.
- Has priority over push and over a pixel tick in the same cycle; both of those are discarded.

Simultaneous events:
- Push and pop on the same edge: `count` is unchanged and both are honoured.
- Push into an empty FIFO on the same edge as a load: no fall-through. The load sees empty, underflows and loads 0; the pushed word is kept for the next load.
- FIFO full: `word_ready`=0, so no push is possible.

Reset (async, any time):
- `phase`=0, FIFO empty.
- `S1S0`=00 (hold), `D`=0, `underflow`=0, `word_ready`=0 while asserted.
- `last_cen`=1, so no tick occurs on the first edge after release even if `Cen` is high.

## Timing
- A word popped at tick T is parallel-loaded into the shifters at tick T+1. Its first pixel appears on shifter `Q3` after tick T+1.
- Load cadence: one load every 4 ticks, the first at the first tick following `line_start` or reset.
- `word_ready` is combinational from `count` and `line_start`; it is never combinational from `word_valid`.
- Minimum sustained input rate without underflow: 1 word per 4 ticks. The FIFO gives 1 word of slack.

## Configuration
- `GFX_LOADER_FLIP_EN` defined:
  - `flip` is sampled at each phase-0 tick and held for that 4-tick group.
  - When `flip`=1, phases 1..3 drive `S1S0`=10 (shift left) instead of 01.
  - The loaded `D` is unchanged; the pixel order reverses because it is taken from `Q0`.
- `GFX_LOADER_FLIP_EN` undefined:
  - `flip` is ignored and the sampling register is not built.
  - Shifting is always right (01).

## Test plan
- Reset then `Cen` held 1: no ticks occur; `S1S0`=00, `D`=0, `word_ready`=1 after release.
- `line_start`, push 0x1234 and 0xABCD, toggle `Cen` for 8 ticks:
  - `S1S0` sequence 11,01,01,01,11,01,01,01.
  - `D`=0x1234 after tick 1 and 0xABCD after tick 5.
  - `underflow`=0.
- Push three words back-to-back with no ticks: the third is stalled (`word_ready`=0 at `count`=2) and accepted only after the next load pops.
- Empty FIFO at a phase-0 tick: `D`=0x0000, `S1S0`=11, `underflow`=1. It stays 1 until `line_start`.
- `line_start` asserted with `word_valid`=1 and FIFO holding 2 words: FIFO is empty afterwards, the word is not accepted, `phase`=0, `S1S0`=11, `D`=0.
- With `GFX_LOADER_FLIP_EN` defined, `flip`=1 at a load: the next three ticks drive `S1S0`=10. Changing `flip` mid-group has no effect until the next load.
